// File: rtl/uart_word_loader.sv
// uart_word_loader: loads a framed, checksummed burst of multi-byte words from UART into a word-addressed RAM port
module uart_rx #(
    parameter int BPS = 217
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       vld
);
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    localparam logic [15:0] FULL = 16'(BPS - 1);
    localparam logic [15:0] HALF = 16'(BPS / 2 - 1);
    rx_state_t  state;
    logic [1:0]  sync;
    logic [15:0] cnt;
    logic [2:0]  idx;
    logic [7:0]  sh;
    // Two-flop synchronise the line, find the start bit, then sample each bit at its centre
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= R_IDLE;
            sync  <= 2'b11;
            cnt   <= '0;
            idx   <= '0;
            sh    <= '0;
            data  <= '0;
            vld   <= 1'b0;
        end else begin
            sync <= {sync[0], rx};
            vld  <= 1'b0;
            case (state)
                R_IDLE: begin
                    cnt <= '0;
                    if (!sync[1]) state <= R_START;
                end
                R_START: begin
                    cnt <= cnt + 16'd1;
                    if (cnt == HALF) begin
                        cnt   <= '0;
                        idx   <= '0;
                        state <= sync[1] ? R_IDLE : R_DATA;
                    end
                end
                R_DATA: begin
                    cnt <= cnt + 16'd1;
                    if (cnt == FULL) begin
                        cnt <= '0;
                        sh  <= {sync[1], sh[7:1]};
                        idx <= idx + 3'd1;
                        if (idx == 3'd7) state <= R_STOP;
                    end
                end
                default: begin
                    cnt <= cnt + 16'd1;
                    if (cnt == FULL) begin
                        state <= R_IDLE;
                        data  <= sh;
                        vld   <= sync[1];
                    end
                end
            endcase
        end
    end
endmodule

module uart_tx #(
    parameter int BPS = 217
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       vld,
    output logic       rdy,
    output logic       tx
);
    localparam logic [15:0] FULL = 16'(BPS - 1);
    logic        act;
    logic [8:0]  sh;
    logic [3:0]  n;
    logic [15:0] cnt;
    assign rdy = !act;
    // Send start bit, eight data bits LSB first, then the stop bit held from the shift register
    always_ff @(posedge clk) begin
        if (rst) begin
            act <= 1'b0;
            sh  <= '0;
            n   <= '0;
            cnt <= '0;
            tx  <= 1'b1;
        end else if (!act) begin
            if (vld) begin
                act <= 1'b1;
                sh  <= {1'b1, data};
                n   <= '0;
                cnt <= '0;
                tx  <= 1'b0;
            end
        end else if (cnt == FULL) begin
            cnt <= '0;
            if (n == 4'd9) begin
                act <= 1'b0;
                tx  <= 1'b1;
            end else begin
                tx <= sh[0];
                sh <= {1'b0, sh[8:1]};
                n  <= n + 4'd1;
            end
        end else begin
            cnt <= cnt + 16'd1;
        end
    end
endmodule

module uart_word_loader #(
    parameter int BPS        = 217,
    parameter int WORD_B     = 4,
    parameter int ADDR_W     = 10,
    parameter int TO_BITS    = 200,
    parameter int BIG_ENDIAN = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    output logic                  tx,
    output logic                  wr_en,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [WORD_B*8-1:0]   wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [15:0]           word_cnt
);
    localparam int          W      = WORD_B * 8;
    localparam logic [23:0] LIMIT  = 24'(BPS * TO_BITS - 1);
    localparam logic [2:0]  LAST_B = 3'(WORD_B - 1);
    localparam logic [7:0]  SYNC   = 8'hA5;
    localparam logic [7:0]  ACK    = 8'h06;
    localparam logic [7:0]  NAK    = 8'h15;
    typedef enum logic [2:0] {IDLE, LEN_H, LEN_L, DATA, CSUM, RESP} state_t;
    state_t      state;
    logic [7:0]  rx_data;
    logic        rx_vld;
    logic        tx_rdy;
    logic        tx_vld;
    logic [7:0]  resp;
    logic [7:0]  sum;
    logic [15:0] len;
    logic [15:0] words;
    logic [2:0]  byte_cnt;
    logic [23:0] to_cnt;
    logic        timed;
    logic [W-1:0] next_word;

    uart_rx #(.BPS(BPS)) u_rx (.clk(clk), .rst(rst), .rx(rx), .data(rx_data), .vld(rx_vld));
    uart_tx #(.BPS(BPS)) u_tx (.clk(clk), .rst(rst), .data(resp), .vld(tx_vld), .rdy(tx_rdy), .tx(tx));

    assign busy  = state != IDLE;
    assign timed = state inside {LEN_H, LEN_L, DATA, CSUM};

    // wr_data doubles as the assembly register: after WORD_B bytes every stale bit has been shifted out
    always_comb begin
        next_word = BIG_ENDIAN != 0 ? (wr_data << 8) | W'(rx_data) : (wr_data >> 8) | (W'(rx_data) << (W - 8));
    end

    // Frame sequencer: sync, length, payload writes, checksum verdict, response handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            word_cnt <= '0;
            tx_vld   <= 1'b0;
            resp     <= '0;
            sum      <= '0;
            len      <= '0;
            words    <= '0;
            byte_cnt <= '0;
            to_cnt   <= '0;
        end else begin
            wr_en  <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            to_cnt <= (timed && !rx_vld) ? to_cnt + 24'd1 : '0;
            if (wr_en) wr_addr <= wr_addr + 1'b1;
            if (timed && !rx_vld && to_cnt == LIMIT) begin
                resp  <= NAK;
                state <= RESP;
            end else begin
                case (state)
                    IDLE: if (rx_vld && rx_data == SYNC) begin
                        state    <= LEN_H;
                        wr_addr  <= '0;
                        sum      <= '0;
                        words    <= '0;
                        byte_cnt <= '0;
                    end
                    LEN_H: if (rx_vld) begin
                        len[15:8] <= rx_data;
                        state     <= LEN_L;
                    end
                    LEN_L: if (rx_vld) begin
                        len[7:0] <= rx_data;
                        state    <= ({len[15:8], rx_data} == 16'd0) ? CSUM : DATA;
                    end
                    DATA: if (rx_vld) begin
                        wr_data <= next_word;
                        sum     <= sum + rx_data;
                        if (byte_cnt == LAST_B) begin
                            byte_cnt <= '0;
                            wr_en    <= 1'b1;
                            words    <= words + 16'd1;
                            if (words == len - 16'd1) state <= CSUM;
                        end else begin
                            byte_cnt <= byte_cnt + 3'd1;
                        end
                    end
                    CSUM: if (rx_vld) begin
                        resp  <= (rx_data == sum) ? ACK : NAK;
                        state <= RESP;
                    end
                    RESP: if (tx_vld) begin
                        tx_vld <= 1'b0;
                        state  <= IDLE;
                    end else if (tx_rdy) begin
                        tx_vld <= 1'b1;
                        done   <= resp == ACK;
                        err    <= resp != ACK;
                        if (resp == ACK) word_cnt <= len;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_word_loader.sv
// tb_uart_word_loader: randomized scoreboard bench over three loader configurations
module tb_uart_word_loader;
    localparam int BPS     = 8;
    localparam int TO_BITS = 40;
    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]  rx_l = 3'b111;
    logic [2:0]  tx_l, wr_en_l, busy_l, done_l, err_l;
    logic [9:0]  a0;
    logic [1:0]  a1, a2;
    logic [31:0] d0;
    logic [15:0] d1;
    logic [7:0]  d2;
    logic [15:0] wc0, wc1, wc2;

    uart_word_loader #(.BPS(BPS), .WORD_B(4), .ADDR_W(10), .TO_BITS(TO_BITS), .BIG_ENDIAN(1)) dut0 (
        .clk(clk), .rst(rst), .rx(rx_l[0]), .tx(tx_l[0]), .wr_en(wr_en_l[0]), .wr_addr(a0), .wr_data(d0),
        .busy(busy_l[0]), .done(done_l[0]), .err(err_l[0]), .word_cnt(wc0));
    uart_word_loader #(.BPS(BPS), .WORD_B(2), .ADDR_W(2), .TO_BITS(TO_BITS), .BIG_ENDIAN(0)) dut1 (
        .clk(clk), .rst(rst), .rx(rx_l[1]), .tx(tx_l[1]), .wr_en(wr_en_l[1]), .wr_addr(a1), .wr_data(d1),
        .busy(busy_l[1]), .done(done_l[1]), .err(err_l[1]), .word_cnt(wc1));
    uart_word_loader #(.BPS(BPS), .WORD_B(1), .ADDR_W(2), .TO_BITS(TO_BITS), .BIG_ENDIAN(1)) dut2 (
        .clk(clk), .rst(rst), .rx(rx_l[2]), .tx(tx_l[2]), .wr_en(wr_en_l[2]), .wr_addr(a2), .wr_data(d2),
        .busy(busy_l[2]), .done(done_l[2]), .err(err_l[2]), .word_cnt(wc2));

    int pass_n = 0;
    int total_n = 0;
    logic [87:0] exp_wr[$];
    logic [15:0] exp_rsp[$];
    logic [15:0] exp_tx[$];
    logic [7:0]  pay[$];
    int          last_cnt[3] = '{0, 0, 0};
    int          tx_t[3] = '{-1, -1, -1};
    logic [7:0]  tx_sh[3];

    function automatic int wb_of(input int k);
        return k == 0 ? 4 : (k == 1 ? 2 : 1);
    endfunction
    function automatic bit be_of(input int k);
        return k != 1;
    endfunction
    function automatic int aw_of(input int k);
        return k == 0 ? 10 : 2;
    endfunction
    function automatic logic [15:0] a_of(input int k);
        return k == 0 ? 16'(a0) : (k == 1 ? 16'(a1) : 16'(a2));
    endfunction
    function automatic logic [63:0] d_of(input int k);
        return k == 0 ? 64'(d0) : (k == 1 ? 64'(d1) : 64'(d2));
    endfunction
    function automatic logic [15:0] wc_of(input int k);
        return k == 0 ? wc0 : (k == 1 ? wc1 : wc2);
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total_n++;
        if (got === exp) pass_n++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // Monitor: pops the scoreboard whenever a DUT writes, flags a verdict, or finishes sending a byte
    always @(negedge clk) begin
        logic [87:0] e;
        logic [15:0] r;
        for (int k = 0; k < 3; k++) begin
            if (wr_en_l[k]) begin
                chk("wr_expected", 64'(exp_wr.size() != 0), 64'd1);
                if (exp_wr.size() != 0) begin
                    e = exp_wr.pop_front();
                    chk("wr_dut", 64'(k), 64'(e[87:80]));
                    chk("wr_addr", 64'(a_of(k)), 64'(e[79:64]));
                    chk("wr_data", d_of(k), e[63:0]);
                end
            end
            if (done_l[k] || err_l[k]) begin
                chk("resp_expected", 64'(exp_rsp.size() != 0), 64'd1);
                if (exp_rsp.size() != 0) begin
                    r = exp_rsp.pop_front();
                    chk("resp_dut", 64'(k), 64'(r[15:8]));
                    chk("done_flag", 64'(done_l[k]), 64'(r[7:0] == ACK));
                    chk("err_flag", 64'(err_l[k]), 64'(r[7:0] == NAK));
                end
            end
            if (tx_t[k] < 0) begin
                if (tx_l[k] === 1'b0) tx_t[k] = 0;
            end else begin
                tx_t[k]++;
                if (tx_t[k] >= 4 + BPS && tx_t[k] < 4 + 9 * BPS && (tx_t[k] - 4) % BPS == 0)
                    tx_sh[k] = {tx_l[k], tx_sh[k][7:1]};
                else if (tx_t[k] == 4 + 9 * BPS) begin
                    chk("tx_stop", 64'(tx_l[k]), 64'd1);
                    chk("tx_expected", 64'(exp_tx.size() != 0), 64'd1);
                    if (exp_tx.size() != 0) begin
                        r = exp_tx.pop_front();
                        chk("tx_dut", 64'(k), 64'(r[15:8]));
                        chk("tx_byte", 64'(tx_sh[k]), 64'(r[7:0]));
                    end
                    tx_t[k] = -1;
                end
            end
        end
    end

    task automatic send_byte(input int k, input logic [7:0] b);
        logic [9:0] bits;
        bits = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_l[k] = bits[i];
            repeat (BPS) @(negedge clk);
        end
    endtask

    task automatic wait_idle(input int k);
        int c;
        c = 0;
        while (busy_l[k] && c < 20000) begin
            @(negedge clk);
            c++;
        end
        chk("idle_reached", 64'(busy_l[k]), 64'd0);
    endtask

    task automatic push_word(input int k, input int i);
        int wb;
        logic [63:0] w;
        wb = wb_of(k);
        w = 0;
        for (int j = 0; j < wb; j++)
            w = w | (64'(pay[i - wb + 1 + j]) << (8 * (be_of(k) ? wb - 1 - j : j)));
        exp_wr.push_back({8'(k), 16'((i / wb) % (1 << aw_of(k))), w});
    endtask

    task automatic fill_rand(input int n);
        pay.delete();
        for (int i = 0; i < n; i++) pay.push_back(8'($urandom_range(0, 255)));
    endtask

    // cut < 0 sends the whole frame; otherwise only cut payload bytes are sent and the line goes quiet
    task automatic run_frame(input int k, input int len, input bit bad, input int cut);
        int wb, n;
        logic [7:0] sum;
        logic [7:0] rsp;
        wb = wb_of(k);
        sum = 0;
        foreach (pay[i]) sum = sum + pay[i];
        send_byte(k, 8'hA5);
        send_byte(k, 8'(len >> 8));
        send_byte(k, 8'(len));
        n = (cut < 0) ? pay.size() : cut;
        for (int i = 0; i < n; i++) begin
            if (i % wb == wb - 1) push_word(k, i);
            send_byte(k, pay[i]);
        end
        rsp = (cut < 0 && !bad) ? ACK : NAK;
        exp_rsp.push_back({8'(k), rsp});
        exp_tx.push_back({8'(k), rsp});
        if (cut < 0) send_byte(k, bad ? sum + 8'h01 : sum);
        wait_idle(k);
        if (rsp == ACK) last_cnt[k] = len;
        chk("word_cnt", 64'(wc_of(k)), 64'(last_cnt[k]));
        repeat (12 * BPS) @(negedge clk);
    endtask

    initial begin
        int k, len, mode;
        repeat (4) @(negedge clk);
        chk("rst_wr_en", 64'(wr_en_l), 64'd0);
        chk("rst_wr_addr", 64'(a0), 64'd0);
        chk("rst_wr_data", 64'(d0), 64'd0);
        chk("rst_done_err", 64'({done_l, err_l}), 64'd0);
        chk("rst_word_cnt", 64'(wc0), 64'd0);
        chk("rst_busy", 64'(busy_l), 64'd0);
        chk("rst_tx", 64'(tx_l), 64'h7);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        pay = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        run_frame(0, 2, 1'b0, -1);
        run_frame(0, 2, 1'b1, -1);

        pay = '{8'hAB, 8'hCD};
        run_frame(1, 1, 1'b0, -1);

        fill_rand(12);
        run_frame(0, 3, 1'b0, 0);
        fill_rand(8);
        run_frame(0, 2, 1'b0, -1);

        send_byte(0, 8'h00);
        send_byte(0, 8'hFF);
        pay.delete();
        run_frame(0, 0, 1'b0, -1);

        fill_rand(5);
        run_frame(2, 5, 1'b0, -1);
        fill_rand(10);
        run_frame(1, 5, 1'b0, -1);

        for (int t = 0; t < 10; t++) begin
            k = $urandom_range(0, 2);
            len = $urandom_range(0, 5);
            mode = $urandom_range(0, 7);
            fill_rand(len * wb_of(k));
            run_frame(k, len, mode == 1 || mode == 2, mode == 0 ? $urandom_range(0, len * wb_of(k)) : -1);
        end

        fill_rand(12);
        send_byte(0, 8'hA5);
        send_byte(0, 8'h00);
        send_byte(0, 8'h03);
        for (int i = 0; i < 5; i++) begin
            if (i == 3) push_word(0, i);
            send_byte(0, pay[i]);
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_rst_wr_en", 64'(wr_en_l), 64'd0);
        chk("mid_rst_wr_addr", 64'(a0), 64'd0);
        chk("mid_rst_wr_data", 64'(d0), 64'd0);
        chk("mid_rst_done_err", 64'({done_l, err_l}), 64'd0);
        chk("mid_rst_word_cnt", 64'({wc0, wc1, wc2}), 64'd0);
        chk("mid_rst_busy", 64'(busy_l), 64'd0);
        rst = 1'b0;
        last_cnt = '{0, 0, 0};
        repeat (30 * BPS) @(negedge clk);
        chk("mid_rst_tx_idle", 64'(tx_l), 64'h7);
        chk("mid_rst_still_idle", 64'(busy_l), 64'd0);

        fill_rand(4);
        run_frame(0, 1, 1'b0, -1);

        chk("wr_left", 64'(exp_wr.size()), 64'd0);
        chk("resp_left", 64'(exp_rsp.size()), 64'd0);
        chk("tx_left", 64'(exp_tx.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
